// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Registered ALU with valid/ready handshake, stored NZCV flags,
//                conditional execution and an iterative shift-add multiplier.
//  Revision    : 1.0
// ============================================================================

module alu_seq #(
    parameter int  WIDTH = 32,
    parameter int  IMM_W = 16,
    localparam int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [IMM_W-1:0] immediate_value,
    input  logic [3:0]       conditions,
    input  logic             s,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             wr_en,
    output logic             skipped,
    output logic [3:0]       flags
);

    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] c_OP_ADD = 4'h0;
    localparam logic [3:0] c_OP_SUB = 4'h1;
    localparam logic [3:0] c_OP_MUL = 4'h2;
    localparam logic [3:0] c_OP_OR  = 4'h3;
    localparam logic [3:0] c_OP_AND = 4'h4;
    localparam logic [3:0] c_OP_XOR = 4'h5;
    localparam logic [3:0] c_OP_LDI = 4'h6;
    localparam logic [3:0] c_OP_MOV = 4'h7;
    localparam logic [3:0] c_OP_LSR = 4'h8;
    localparam logic [3:0] c_OP_LSL = 4'h9;
    localparam logic [3:0] c_OP_ROR = 4'hA;
    localparam logic [3:0] c_OP_CMP = 4'hB;

    localparam logic [SH_W-1:0] c_CNT_LAST = SH_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic               w_accept;
    logic               w_cond_pass;
    logic               w_mul_last;

    logic [WIDTH-1:0]   w_res;
    logic               w_wr;
    logic               w_upd;
    logic               w_c;
    logic               w_v;
    logic [3:0]         w_new_flags;

    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [SH_W-1:0]    w_sh;
    logic [SH_W-1:0]    w_sh_m1;
    logic [SH_W-1:0]    w_lsl_idx;

    logic [SH_W-1:0]    r_count;
    logic [2*WIDTH-1:0] r_prod;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_mul_s;
    logic [2*WIDTH-1:0] w_prod_next;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_wr_en;
    logic               r_skipped;
    logic [3:0]         r_flags;

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign wr_en     = r_wr_en;
    assign skipped   = r_skipped;
    assign flags     = r_flags;

    // An all-zero mask always passes since (flags & 0) == 0.
    assign w_cond_pass = (conditions == 4'b0000) || ((r_flags & conditions) == conditions);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        w_accept     = 1'b0;
        w_mul_last   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid && w_cond_pass && (op_code == c_OP_MUL)) begin
                    w_state_next = S_MUL;
                end
            end
            S_MUL: begin
                if (r_count == c_CNT_LAST) begin
                    w_mul_last   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_add     = {1'b0, src1} + {1'b0, src2};
    assign w_sub     = {1'b0, src1} - {1'b0, src2};
    assign w_sh      = immediate_value[SH_W-1:0];
    assign w_sh_m1   = w_sh - SH_W'(1);
    // WIDTH - n taken modulo WIDTH; also the rotate's left-shift amount.
    assign w_lsl_idx = SH_W'(0) - w_sh;

    always_comb begin
        w_res = '0;
        w_wr  = 1'b1;
        w_upd = 1'b0;
        w_c   = r_flags[1];
        w_v   = 1'b0;
        case (op_code)
            c_OP_ADD: begin
                w_res = w_add[WIDTH-1:0];
                w_c   = w_add[WIDTH];
                w_v   = (src1[MSB] == src2[MSB]) && (w_add[MSB] != src1[MSB]);
                w_upd = s;
            end
            c_OP_SUB, c_OP_CMP: begin
                w_res = w_sub[WIDTH-1:0];
                w_c   = ~w_sub[WIDTH];
                w_v   = (src1[MSB] != src2[MSB]) && (w_sub[MSB] != src1[MSB]);
                w_upd = s || (op_code == c_OP_CMP);
                w_wr  = (op_code != c_OP_CMP);
            end
            c_OP_MUL: begin
                w_res = '0;
            end
            c_OP_OR:  w_res = src1 | src2;
            c_OP_AND: w_res = src1 & src2;
            c_OP_XOR: w_res = src1 ^ src2;
            c_OP_LDI: w_res = WIDTH'(immediate_value);
            c_OP_MOV: w_res = src1;
            c_OP_LSR: begin
                w_res = src1 >> w_sh;
                if (w_sh != '0) begin
                    w_c = src1[w_sh_m1];
                end
                w_upd = s;
            end
            c_OP_LSL: begin
                w_res = src1 << w_sh;
                if (w_sh != '0) begin
                    w_c = src1[w_lsl_idx];
                end
                w_upd = s;
            end
            c_OP_ROR: begin
                w_res = (src1 >> w_sh) | (src1 << w_lsl_idx);
                if (w_sh != '0) begin
                    w_c = src1[w_sh_m1];
                end
                w_upd = s;
            end
            default: begin
                w_res = '0;
                w_wr  = 1'b0;
            end
        endcase
        w_new_flags = {w_res[MSB], (w_res == '0), w_c, w_v};
    end

    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_wr_en     <= 1'b0;
            r_skipped   <= 1'b0;
            r_flags     <= 4'b0000;
            r_count     <= '0;
            r_prod      <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_mul_s     <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
                if (!w_cond_pass) begin
                    r_out_valid <= 1'b1;
                    r_result    <= '0;
                    r_wr_en     <= 1'b0;
                    r_skipped   <= 1'b1;
                end else if (op_code == c_OP_MUL) begin
                    r_prod   <= '0;
                    r_mcand  <= {{WIDTH{1'b0}}, src1};
                    r_mplier <= src2;
                    r_mul_s  <= s;
                    r_count  <= '0;
                end else begin
                    r_out_valid <= 1'b1;
                    r_result    <= w_res;
                    r_wr_en     <= w_wr;
                    r_skipped   <= 1'b0;
                    if (w_upd) begin
                        r_flags <= w_new_flags;
                    end
                end
            end else if (r_state == S_MUL) begin
                r_prod   <= w_prod_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count + SH_W'(1);
                if (w_mul_last) begin
                    r_out_valid <= 1'b1;
                    r_result    <= w_prod_next[WIDTH-1:0];
                    r_wr_en     <= 1'b1;
                    r_skipped   <= 1'b0;
                    if (r_mul_s) begin
                        r_flags <= {w_prod_next[MSB], (w_prod_next[WIDTH-1:0] == '0),
                                    (w_prod_next[2*WIDTH-1:WIDTH] != '0), 1'b0};
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Directed and randomised checks of alu_seq against a
//                behavioural model of the operation set.
//  Revision    : 1.0
// ============================================================================

module tb_alu_seq;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op_code;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic [15:0] immediate_value;
    logic [3:0]  conditions;
    logic        s;
    logic        out_valid;
    logic [W-1:0] result;
    logic        wr_en;
    logic        skipped;
    logic [3:0]  flags;

    int checks = 0;
    int fails  = 0;
    logic started = 1'b0;

    alu_seq #(.WIDTH(W), .IMM_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_code(op_code), .src1(src1), .src2(src2),
        .immediate_value(immediate_value), .conditions(conditions), .s(s),
        .out_valid(out_valid), .result(result), .wr_en(wr_en),
        .skipped(skipped), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_busy;
    logic        m_vld;
    logic [W-1:0] m_res;
    logic        m_wr;
    logic        m_skip;
    logic [3:0]  m_flags;
    logic [W-1:0] p_res;
    logic [3:0]  p_flags;

    function automatic void model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [15:0] imm, input logic sf, input logic [3:0] fin,
                                     output logic [31:0] res, output logic wr, output logic [3:0] fout);
        longint sa, sb, sr;
        logic [63:0] t;
        int n;
        logic c, v, upd;
        res = 0; wr = 1'b1; c = fin[1]; v = 1'b0; upd = 1'b0;
        n  = int'(imm[4:0]);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0: begin
                t = {32'b0, a} + {32'b0, b};
                res = t[31:0]; c = t[32];
                sr = sa + sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
                upd = sf;
            end
            4'd1, 4'd11: begin
                res = a - b; c = (a >= b);
                sr = sa - sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
                upd = sf || (op == 4'd11); wr = (op != 4'd11);
            end
            4'd2: begin
                t = {32'b0, a} * {32'b0, b};
                res = t[31:0]; c = (t[63:32] != 0); upd = sf;
            end
            4'd3: res = a | b;
            4'd4: res = a & b;
            4'd5: res = a ^ b;
            4'd6: res = {16'b0, imm};
            4'd7: res = a;
            4'd8: begin res = a >> n; if (n != 0) c = a[n-1]; upd = sf; end
            4'd9: begin res = a << n; if (n != 0) c = a[32-n]; upd = sf; end
            4'd10: begin
                res = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
                if (n != 0) c = a[n-1];
                upd = sf;
            end
            default: begin res = 0; wr = 1'b0; end
        endcase
        fout = upd ? {res[31], (res == 0), c, v} : fin;
    endfunction

    always @(posedge clk) begin
        logic [31:0] r;
        logic        w;
        logic [3:0]  f;
        if (reset) begin
            m_busy = 0; m_vld = 0; m_res = 0; m_wr = 0; m_skip = 0; m_flags = 0;
        end else begin
            m_vld = 1'b0;
            if (m_busy != 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_vld = 1; m_res = p_res; m_wr = 1; m_skip = 0; m_flags = p_flags;
                end
            end else if (in_valid) begin
                if (conditions != 0 && (m_flags & conditions) != conditions) begin
                    m_vld = 1; m_res = 0; m_wr = 0; m_skip = 1;
                end else begin
                    model_op(op_code, src1, src2, immediate_value, s, m_flags, r, w, f);
                    if (op_code == 4'd2) begin
                        m_busy = W; p_res = r; p_flags = f;
                    end else begin
                        m_vld = 1; m_res = r; m_wr = w; m_skip = 0; m_flags = f;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", 64'(in_ready), 64'(m_busy == 0));
            chk("out_valid", 64'(out_valid), 64'(m_vld));
            chk("flags", 64'(flags), 64'(m_flags));
            chk("result", 64'(result), 64'(m_res));
            if (m_vld) begin
                chk("wr_en", 64'(wr_en), 64'(m_wr));
                chk("skipped", 64'(skipped), 64'(m_skip));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] imm, input logic [3:0] cond, input logic sf);
        op_code = op; src1 = a; src2 = b; immediate_value = imm;
        conditions = cond; s = sf; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] pick(input int k);
        case (k)
            0: pick = 32'h0000_0000;
            1: pick = 32'h0000_0001;
            2: pick = 32'h7FFF_FFFF;
            3: pick = 32'h8000_0000;
            4: pick = 32'hFFFF_FFFF;
            default: pick = $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; in_valid = 1'b0; op_code = 0; src1 = 0; src2 = 0;
        immediate_value = 0; conditions = 0; s = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        started = 1'b1;

        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst result", 64'(result), 64'd0);
        chk("rst flags", 64'(flags), 64'd0);
        chk("rst wr_en", 64'(wr_en), 64'd0);
        chk("rst skipped", 64'(skipped), 64'd0);

        // signed overflow on ADD
        drive(4'd0, 32'h7FFF_FFFF, 32'h1, 16'h0, 4'h0, 1'b1);
        chk("add ov valid", 64'(out_valid), 64'd1);
        chk("add ov result", 64'(result), 64'h8000_0000);
        chk("add ov wr_en", 64'(wr_en), 64'd1);
        chk("add ov flags", 64'(flags), 64'b1001);

        // back-to-back CMP then SUB
        drive(4'd11, 32'd5, 32'd5, 16'h0, 4'h0, 1'b1);
        chk("cmp wr_en", 64'(wr_en), 64'd0);
        chk("cmp flags", 64'(flags), 64'b0110);
        chk("cmp in_ready", 64'(in_ready), 64'd1);
        drive(4'd1, 32'd3, 32'd5, 16'h0, 4'h0, 1'b1);
        chk("sub result", 64'(result), 64'hFFFF_FFFE);
        chk("sub flags", 64'(flags), 64'b1000);
        chk("sub in_ready", 64'(in_ready), 64'd1);

        // logic, load and move ops leave flags alone
        drive(4'd3, 32'hF0, 32'h0F, 16'h0, 4'h0, 1'b1);
        chk("or result", 64'(result), 64'hFF);
        chk("or flags", 64'(flags), 64'b1000);
        drive(4'd6, 32'h0, 32'h0, 16'hBEEF, 4'h0, 1'b1);
        chk("ldi result", 64'(result), 64'h0000_BEEF);
        drive(4'd5, 32'hFFFF_0000, 32'h0F0F_0F0F, 16'h0, 4'h0, 1'b0);
        chk("xor result", 64'(result), 64'hF0F0_0F0F);
        drive(4'd12, 32'h1234, 32'h1, 16'h0, 4'h0, 1'b1);
        chk("nop result", 64'(result), 64'd0);
        chk("nop wr_en", 64'(wr_en), 64'd0);
        chk("nop valid", 64'(out_valid), 64'd1);

        // zero shift keeps C, one-bit LSR sets it
        drive(4'd8, 32'h8000_0000, 32'h0, 16'h0, 4'h0, 1'b1);
        chk("lsr0 result", 64'(result), 64'h8000_0000);
        chk("lsr0 flags", 64'(flags), 64'b1000);
        drive(4'd8, 32'h3, 32'h0, 16'h1, 4'h0, 1'b1);
        chk("lsr1 result", 64'(result), 64'h1);
        chk("lsr1 flags", 64'(flags), 64'b0010);

        // multiply with busy window
        drive(4'd2, 32'h0001_0000, 32'h0001_0000, 16'h0, 4'h0, 1'b1);
        op_code = 4'd0; src1 = 32'd1; src2 = 32'd1; conditions = 0; s = 0; in_valid = 1'b1;
        for (int i = 1; i <= W; i++) begin
            chk("mul busy in_ready", 64'(in_ready), 64'd0);
            chk("mul busy out_valid", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("mul valid", 64'(out_valid), 64'd1);
        chk("mul result", 64'(result), 64'd0);
        chk("mul flags", 64'(flags), 64'b0110);
        @(posedge clk); #1;
        chk("mul no extra accept", 64'(out_valid), 64'd0);

        drive(4'd2, 32'd12345, 32'd6789, 16'h0, 4'h0, 1'b1);
        repeat (W) @(posedge clk);
        #1 chk("mul2 result", 64'(result), 64'd83810205);

        // rotate and left shift
        drive(4'd10, 32'h1, 32'h0, 16'h1, 4'h0, 1'b1);
        chk("ror result", 64'(result), 64'h8000_0000);
        chk("ror flags", 64'(flags), 64'b1010);
        drive(4'd9, 32'h8000_0000, 32'h0, 16'h1, 4'h0, 1'b1);
        chk("lsl result", 64'(result), 64'd0);
        chk("lsl flags", 64'(flags), 64'b0110);

        // conditional execution against Z,C set
        drive(4'd0, 32'd1, 32'd1, 16'h0, 4'b0100, 1'b0);
        chk("cond pass result", 64'(result), 64'd2);
        chk("cond pass skipped", 64'(skipped), 64'd0);
        drive(4'd0, 32'd1, 32'd1, 16'h0, 4'b1000, 1'b1);
        chk("cond fail skipped", 64'(skipped), 64'd1);
        chk("cond fail wr_en", 64'(wr_en), 64'd0);
        chk("cond fail result", 64'(result), 64'd0);
        chk("cond fail flags", 64'(flags), 64'b0110);
        drive(4'd2, 32'd3, 32'd3, 16'h0, 4'b1000, 1'b1);
        chk("mul skip valid", 64'(out_valid), 64'd1);
        chk("mul skip skipped", 64'(skipped), 64'd1);
        chk("mul skip in_ready", 64'(in_ready), 64'd1);

        // reset in the middle of a multiply
        drive(4'd2, 32'd7, 32'd9, 16'h0, 4'h0, 1'b1);
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort in_ready", 64'(in_ready), 64'd1);
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort flags", 64'(flags), 64'd0);
        drive(4'd0, 32'd2, 32'd3, 16'h0, 4'h0, 1'b0);
        chk("post abort result", 64'(result), 64'd5);
        chk("post abort valid", 64'(out_valid), 64'd1);

        // randomised mix checked by the model
        for (int i = 0; i < 80; i++) begin
            op_code         = 4'($urandom_range(0, 15));
            src1            = pick(int'($urandom_range(0, 6)));
            src2            = pick(int'($urandom_range(0, 6)));
            immediate_value = 16'($urandom);
            conditions      = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            s               = 1'($urandom);
            in_valid        = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the datapath ALU. It accepts one operation per cycle through a valid/ready handshake and holds the NZCV status flags in an internal register. It supports conditional execution against those stored flags and computes MUL with an iterative shift-add engine. It sits between the decode/register-read stage and register writeback; `wr_en` tells writeback whether the destination is written.

Parameters:
WIDTH, 32, datapath width of src1, src2 and result (must be >= 8, power of 2).
IMM_W, 16, width of immediate_value (must be <= WIDTH).
SH_W, $clog2(WIDTH), number of immediate bits used as the shift/rotate amount (derived, not overridden).

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  operation present on inputs
in_ready  out  1  block can accept an operation this cycle
op_code  in  4  operation select
src1  in  WIDTH  operand A
src2  in  WIDTH  operand B
immediate_value  in  IMM_W  immediate / shift amount
conditions  in  4  required flag mask {N,Z,C,V}; 0000 = always
s  in  1  set-flags enable
out_valid  out  1  one-cycle pulse; result/wr_en/skipped valid
result  out  WIDTH  operation result
wr_en  out  1  writeback should write result
skipped  out  1  operation squashed by its condition
flags  out  4  registered {N,Z,C,V}; N = flags[3]

Behaviour:
- Interface decision: one clock, `clk`; reset `reset` is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, result=0, wr_en=0, skipped=0, flags=4'b0000, FSM=IDLE, counter=0.
- Reset mid-multiply aborts the operation; no out_valid is produced for it.
- Accept: an operation is accepted on a rising edge where in_valid && in_ready. Inputs are sampled only at accept.
- FSM has two states, IDLE and MUL.
  - IDLE: in_ready=1. A non-MUL accept updates result/flags/wr_en/skipped; out_valid=1 on the next cycle (latency 1, throughput 1/cycle, back-to-back allowed).
  - An accepted MUL (op 0010) that passes its condition goes to MUL.
  - MUL: in_ready=0. It runs WIDTH shift-add iterations, one per cycle, building a 2*WIDTH product, then returns to IDLE with out_valid=1. Latency from accept to out_valid is WIDTH+1 cycles.
- Outside a pulse, out_valid=0 and result holds its last value.
- Condition check uses the flag register value at accept, i.e. including the update from the op accepted in the previous cycle.
  - Pass when conditions==0000 or (flags & conditions)==conditions.
  - On fail: out_valid=1 next cycle, skipped=1, wr_en=0, result=0, flags unchanged. A failing MUL does not enter MUL.
- Ops (ops 0000–1011 give wr_en=1 unless noted):
  - 0000 ADD, 0001 SUB (src1-src2), 0010 MUL (low WIDTH bits).
  - 0011 OR, 0100 AND, 0101 XOR.
  - 0110 LDI: zero-extended immediate.
  - 0111 MOV: result = src1.
  - 1000 LSR, 1001 LSL, 1010 ROR: src1 by immediate_value[SH_W-1:0].
  - 1011 CMP: SUB with wr_en=0; flags always updated.
  - 1100–1111 NOP: out_valid pulse, wr_en=0, result=0, flags unchanged.
- Flag update occurs only when s=1 (CMP: always) and only for ADD, SUB, MUL, shifts, rotate and CMP. Logic ops, LDI and MOV never change flags. In all cases N=result[WIDTH-1] and Z=(result==0).
  - ADD: C = carry-out. V = src1 and src2 share a sign and result's sign differs.
  - SUB/CMP: C = no-borrow (src1 >= src2 unsigned). V = src1 and src2 differ in sign and result's sign differs from src1.
  - MUL: C = upper WIDTH bits of the product nonzero; V=0.
  - LSR/ROR: C = last bit shifted out (src1[n-1]). LSL: C = src1[WIDTH-n]. V=0.
  - Shift amount n=0: result=src1; C keeps its old value; N/Z still update.
- All arithmetic is modulo 2^WIDTH; operands are treated as unsigned, except for the V computation.

Test Plan:
1. ADD 0x7FFFFFFF + 0x00000001, s=1, conditions=0 -> next cycle out_valid=1, result=0x80000000, wr_en=1, flags=4'b1001.
2. CMP 5,5 then SUB 3-5 with s=1 on the following cycle (back-to-back).
   - CMP -> wr_en=0, flags=4'b0110.
   - SUB -> result=0xFFFFFFFE, flags=4'b1000.
   - in_ready never drops.
3. MUL 0x00010000 * 0x00010000, s=1 -> in_ready=0 for 32 cycles; out_valid on cycle 33 after accept; result=0; flags=4'b0110. Asserting in_valid during MUL is not accepted.
4. ROR 0x00000001 by 1, s=1 -> result=0x80000000, flags=4'b1010. LSL 0x80000000 by 1 -> result=0, flags=4'b0110.
5. With flags=4'b0110: ADD conditions=0100 executes. ADD conditions=1000 -> skipped=1, wr_en=0, result=0, flags stay 0110. A MUL with conditions=1000 also skips with latency 1.
6. Assert reset on cycle 10 of a MUL -> next cycle in_ready=1, out_valid=0, flags=0. A new ADD 2+3 is accepted immediately -> result=5.
